// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: destination scoreboard, stall/bubble/flush/freeze, HALT drain.
// Define WISC_FWD_EN to drive EX operand forward selects and stall only on load-use.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 4,
    parameter int STAGES = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wr,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_is_load,
    input  logic              id_halt,
    input  logic              ex_redirect,
    input  logic              mem_busy,
    output logic              stall_if_id,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic              freeze,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int D   = STAGES - 2;
    localparam int DCW = $clog2(D + 1);
    localparam int S1  = (D > 2) ? 1 : 0;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } sb_ent_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    sb_ent_t [D-1:0]  sb_q, sb_d;
    state_t           state_q, state_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Slot 0 is EX, D-1 is WB; the WB slot writes the regfile this cycle so it never matches.
    logic [D-2:0] m_rs, m_rt;
    always_comb begin
        for (int s = 0; s < D - 1; s++) begin
            m_rs[s] = sb_q[s].v && (sb_q[s].rd == id_rs) && (id_rs != '0) && id_rt_used_or(1'b0, id_rs_used);
            m_rt[s] = sb_q[s].v && (sb_q[s].rd == id_rt) && (id_rt != '0) && id_rt_used_or(1'b0, id_rt_used);
        end
    end

    function automatic logic id_rt_used_or(input logic a, input logic b);
        return a | b;
    endfunction

    logic       hazard;
    logic [1:0] fwd_a_c, fwd_b_c;
`ifdef WISC_FWD_EN
    // Only a load in EX cannot be forwarded in time.
    assign hazard  = (m_rs[0] | m_rt[0]) & sb_q[0].ld;
    assign fwd_a_c = m_rs[0] ? 2'd1 : ((D > 2) && m_rs[S1]) ? 2'd2 : 2'd0;
    assign fwd_b_c = m_rt[0] ? 2'd1 : ((D > 2) && m_rt[S1]) ? 2'd2 : 2'd0;
`else
    assign hazard  = |(m_rs | m_rt);
    assign fwd_a_c = 2'd0;
    assign fwd_b_c = 2'd0;
`endif

    logic unused_sb;
    assign unused_sb = ^sb_q;

    logic frz, redir, haz_stall;
    logic stall_c, bubble_c, flush_c, halted_c;

    assign frz       = mem_busy;
    assign redir     = (ex_redirect | pend_q) & ~frz;
    assign haz_stall = hazard & id_valid & ~frz;

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        cnt_d    = cnt_q;
        pend_d   = frz ? (pend_q | ex_redirect) : 1'b0;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        halted_c = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redir) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (haz_stall) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end else if (id_valid && id_halt && !frz) begin
                    state_d = DRAIN;
                    drain_d = DCW'(D);
                end
            end
            DRAIN: begin
                if (redir) begin
                    // HLT came down the wrong path; resume normal issue.
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    state_d  = RUN;
                end else if (!frz) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (drain_q <= DCW'(1)) state_d = HALTED;
                    else                    drain_d = drain_q - 1'b1;
                end
            end
            HALTED: begin
                halted_c = 1'b1;
                stall_c  = ~frz;
                bubble_c = ~frz;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        sb_d = sb_q;
        if (!frz) begin
            sb_d[0].v  = id_valid & id_wr & (id_rd != '0) & ~bubble_c;
            sb_d[0].rd = id_rd;
            sb_d[0].ld = id_is_load;
            for (int s = 1; s < D; s++) sb_d[s] = sb_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q    <= '0;
            state_q <= RUN;
            drain_q <= '0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sb_q    <= sb_d;
            state_q <= state_d;
            drain_q <= drain_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_if_id = stall_c  & ~rst;
    assign bubble_idex = bubble_c & ~rst;
    assign flush_ifid  = flush_c  & ~rst;
    assign freeze      = frz      & ~rst;
    assign halted      = halted_c & ~rst;
    assign fwd_a       = rst ? 2'd0 : fwd_a_c;
    assign fwd_b       = rst ? 2'd0 : fwd_b_c;
    assign stall_cnt   = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver queues hand-computed expectations, monitor checks at negedge.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid = 0, id_rs_used = 0, id_rt_used = 0, id_wr = 0, id_is_load = 0, id_halt = 0;
    logic [3:0] id_rs = 0, id_rt = 0, id_rd = 0;
    logic ex_redirect = 0, mem_busy = 0;
    logic stall_if_id, bubble_idex, flush_ifid, freeze, halted;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic s_stall, s_bub, s_flush, s_frz, s_halt;
    logic [1:0] s_fa, s_fb;
    logic [3:0] s_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr(id_wr), .id_rd(id_rd),
        .id_is_load(id_is_load), .id_halt(id_halt), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .stall_if_id(stall_if_id), .bubble_idex(bubble_idex), .flush_ifid(flush_ifid), .freeze(freeze),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr(id_wr), .id_rd(id_rd),
        .id_is_load(id_is_load), .id_halt(id_halt), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .stall_if_id(s_stall), .bubble_idex(s_bub), .flush_ifid(s_flush), .freeze(s_frz),
        .fwd_a(s_fa), .fwd_b(s_fb), .halted(s_halt), .stall_cnt(s_cnt)
    );

`ifdef WISC_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        string    nm;
        bit       st, bu, fl, fz, ha;
        bit [1:0] fa, fb;
        int       cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ecnt   = 0;

    task automatic chk(input string nm, input string f, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s got %0d expected %0d", nm, f, act, exp);
        end
    endtask

    // Monitor: every presented cycle with a queued expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "stall",  int'(stall_if_id), int'(e.st));
                chk(e.nm, "bubble", int'(bubble_idex), int'(e.bu));
                chk(e.nm, "flush",  int'(flush_ifid),  int'(e.fl));
                chk(e.nm, "freeze", int'(freeze),      int'(e.fz));
                chk(e.nm, "halted", int'(halted),      int'(e.ha));
                chk(e.nm, "fwd_a",  int'(fwd_a),       int'(e.fa));
                chk(e.nm, "fwd_b",  int'(fwd_b),       int'(e.fb));
                chk(e.nm, "cnt",    int'(stall_cnt),   e.cnt);
                chk(e.nm, "sat_cnt", int'(s_cnt), (e.cnt > 15) ? 15 : e.cnt);
                chk(e.nm, "sat_ctl", int'({s_stall, s_bub, s_flush, s_frz, s_halt, s_fa, s_fb}),
                    int'({e.st, e.bu, e.fl, e.fz, e.ha, e.fa, e.fb}));
            end
        end
    end

    task automatic tick(input string nm, input bit st, bu, fl, fz, ha,
                        input bit [1:0] fa, fb, input bit inc);
        exp_t e;
        e.nm = nm; e.st = st; e.bu = bu; e.fl = fl; e.fz = fz; e.ha = ha;
        e.fa = fa; e.fb = fb; e.cnt = ecnt;
        q.push_back(e);
        if (inc) ecnt++;
        @(posedge clk); #1;
    endtask

    task automatic ok0(input string nm);
        tick(nm, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
    endtask

    task automatic stl(input string nm, input bit [1:0] fa, fb);
        tick(nm, 1, 1, 0, 0, 0, fa, fb, 1);
    endtask

    task automatic clr();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_wr = 0; id_rd = 0; id_is_load = 0; id_halt = 0; ex_redirect = 0; mem_busy = 0;
    endtask

    task automatic set_id(input logic [3:0] rs, rt, input bit rsu, rtu, wr,
                          input logic [3:0] rd, input bit ld, hlt);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
        id_wr = wr; id_rd = rd; id_is_load = ld; id_halt = hlt;
    endtask

    task automatic nops(input int n, input string nm);
        clr();
        repeat (n) ok0(nm);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout pending=%0d expected 0", q.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        @(posedge clk); #1;
        // Reset with noisy inputs: every output must stay low.
        set_id(3, 3, 1, 1, 1, 3, 1, 1);
        mem_busy = 1; ex_redirect = 1;
        ok0("rst_a");
        ok0("rst_b");
        rst = 0;
        nops(2, "idle");

        // ALU producer then consumer on rs.
        set_id(1, 2, 1, 1, 1, 3, 0, 0);
        ok0("raw_prod");
        set_id(3, 2, 1, 1, 1, 4, 0, 0);
`ifdef WISC_FWD_EN
        tick("raw_fwd", 0, 0, 0, 0, 0, 2'd1, 2'd0, 0);
`else
        stl("raw_s1", 0, 0);
        stl("raw_s2", 0, 0);
        ok0("raw_go");
`endif
        nops(3, "drain1");

        // Producer two ahead, consumer on rt; unused rt never hazards.
        set_id(1, 2, 1, 1, 1, 3, 0, 0);
        ok0("rt_prod");
        set_id(0, 3, 0, 0, 0, 0, 0, 0);
        ok0("rt_unused");
        set_id(1, 3, 1, 1, 1, 8, 0, 0);
`ifdef WISC_FWD_EN
        tick("rt_fwd", 0, 0, 0, 0, 0, 2'd0, 2'd2, 0);
`else
        stl("rt_s1", 0, 0);
        ok0("rt_go");
`endif
        nops(3, "drain2");

        // Load-use, first held by a freeze.
        set_id(0, 0, 0, 0, 1, 5, 1, 0);
        ok0("lw_prod");
        set_id(5, 1, 1, 1, 1, 6, 0, 0);
        mem_busy = 1;
        tick("lu_frz", 0, 0, 0, 1, 0, FWD ? 2'd1 : 2'd0, 2'd0, 0);
        mem_busy = 0;
        stl("lu_s1", FWD ? 2'd1 : 2'd0, 2'd0);
`ifdef WISC_FWD_EN
        tick("lu_fwd", 0, 0, 0, 0, 0, 2'd2, 2'd0, 0);
`else
        stl("lu_s2", 0, 0);
        ok0("lu_go");
`endif
        nops(3, "drain3");

        // R0 is never a hazard.
        set_id(0, 0, 0, 0, 1, 0, 0, 0);
        ok0("r0_wr");
        set_id(0, 0, 1, 1, 1, 7, 0, 0);
        ok0("r0_rd");
        nops(2, "drain4");

        // Redirect arriving during a 3-cycle freeze is deferred.
        ex_redirect = 1; mem_busy = 1;
        tick("rd_f1", 0, 0, 0, 1, 0, 2'd0, 2'd0, 0);
        ex_redirect = 0;
        tick("rd_f2", 0, 0, 0, 1, 0, 2'd0, 2'd0, 0);
        tick("rd_f3", 0, 0, 0, 1, 0, 2'd0, 2'd0, 0);
        mem_busy = 0;
        tick("rd_go", 0, 1, 1, 0, 0, 2'd0, 2'd0, 0);
        ok0("rd_done");

        // Redirect beats a data hazard.
        set_id(1, 2, 1, 1, 1, 3, 0, 0);
        ok0("rh_prod");
        set_id(3, 3, 1, 1, 1, 4, 0, 0);
        ex_redirect = 1;
        tick("rd_haz", 0, 1, 1, 0, 0, FWD ? 2'd1 : 2'd0, FWD ? 2'd1 : 2'd0, 0);
        nops(3, "drain5");

        // HLT drains for D cycles then halts.
        set_id(0, 0, 0, 0, 0, 0, 0, 1);
        ok0("hlt");
        clr();
        tick("dr1", 1, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        tick("dr2", 1, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        tick("dr3", 1, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        tick("halt", 1, 1, 0, 0, 1, 2'd0, 2'd0, 0);
        ex_redirect = 1;
        tick("halt_hold", 1, 1, 0, 0, 1, 2'd0, 2'd0, 0);
        clr();
        mem_busy = 1;
        rst = 1; ecnt = 0;
        ok0("rst_halt");
        rst = 0;
        nops(2, "post_rst");

        // Repeated load-use to push the narrow counter past saturation.
        for (int i = 0; i < 20; i++) begin
            set_id(0, 0, 0, 0, 1, 3, 1, 0);
            ok0("sat_lw");
            set_id(3, 0, 1, 0, 1, 4, 0, 0);
`ifdef WISC_FWD_EN
            stl("sat_s1", 2'd1, 2'd0);
            tick("sat_fwd", 0, 0, 0, 0, 0, 2'd2, 2'd0, 0);
`else
            stl("sat_s1", 0, 0);
            stl("sat_s2", 0, 0);
            ok0("sat_go");
`endif
        end
        nops(3, "drain6");

        // Reset in the middle of a drain.
        set_id(0, 0, 0, 0, 0, 0, 0, 1);
        ok0("hlt2");
        clr();
        tick("dr_mid", 1, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        rst = 1; ecnt = 0;
        ok0("rst_drain");
        rst = 0;
        nops(5, "run_after");

        // Redirect during drain cancels the halt.
        set_id(0, 0, 0, 0, 0, 0, 0, 1);
        ok0("hlt3");
        clr();
        tick("d6", 1, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        ex_redirect = 1;
        tick("d6_redir", 0, 1, 1, 0, 0, 2'd0, 2'd0, 0);
        nops(5, "d6_run");

        repeat (4) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue pending=%0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
